// File: rtl/gpio_axi_master.sv
// gpio_axi_master: AXI-Lite initiator issuing one single-beat read or write at a time.
// Define GPIO_AXI_MASTER_TIMEOUT_EN to build the bus-wait watchdog that aborts with rsp_err.
module gpio_axi_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] WAddress,
    output logic        AWvalid,
    input  logic        AWready,
    output logic [31:0] Wdata,
    output logic        Wvalid,
    input  logic        Wready,
    input  logic        Bvalid,
    output logic        Bready,
    output logic [31:0] RAddress,
    output logic        ARvalid,
    input  logic        ARready,
    input  logic        Rvalid,
    output logic        Rready,
    input  logic [31:0] Rdata
);
    // state | meaning
    // IDLE  | cmd_ready high, waiting for a command
    // WREQ  | AW and W valids outstanding, each dropped on its own handshake
    // WRESP | Bready high, waiting for the write response
    // RREQ  | ARvalid high, waiting for ARready
    // RDATA | Rready high, waiting for read data
    // DONE  | rsp_valid high until the requester takes it
    typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RDATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] rdata_q, rdata_d;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("gpio_axi_master: TIMEOUT must be at least 1");
    end

`ifdef GPIO_AXI_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          expired;

    // Abort on the TIMEOUT-th consecutive cycle spent in one wait state.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        rdata_d     = rdata_q;
`ifdef GPIO_AXI_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    waddr_d     = cmd_addr;
                    raddr_d     = cmd_addr;
                    wdata_d     = cmd_wdata;
                    rdata_d     = '0;
`ifdef GPIO_AXI_MASTER_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    if (cmd_write) begin
                        state_d    = WREQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RREQ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WREQ: begin
                if (aw_valid_q && AWready) aw_valid_d = 1'b0;
                if (w_valid_q && Wready)   w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = WRESP;
                    b_ready_d = 1'b1;
                end
            end
            WRESP: begin
                if (Bvalid) begin
                    state_d     = DONE;
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            RREQ: begin
                if (ARready) begin
                    state_d    = RDATA;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            RDATA: begin
                if (Rvalid) begin
                    state_d     = DONE;
                    r_ready_d   = 1'b0;
                    rdata_d     = Rdata;
                    rsp_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef GPIO_AXI_MASTER_TIMEOUT_EN
        // A handshake landing on the expiry cycle wins over the abort.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {WREQ, WRESP, RREQ, RDATA}) begin
            if (expired) begin
                state_d     = DONE;
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                b_ready_d   = 1'b0;
                ar_valid_d  = 1'b0;
                r_ready_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rdata_d     = '0;
                err_d       = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rdata_q     <= '0;
`ifdef GPIO_AXI_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            rdata_q     <= rdata_d;
`ifdef GPIO_AXI_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign WAddress  = waddr_q;
    assign AWvalid   = aw_valid_q;
    assign Wdata     = wdata_q;
    assign Wvalid    = w_valid_q;
    assign Bready    = b_ready_q;
    assign RAddress  = raddr_q;
    assign ARvalid   = ar_valid_q;
    assign Rready    = r_ready_q;
`ifdef GPIO_AXI_MASTER_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
